// File: rtl/exe_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_unit
// Purpose  : Execute stage of a 5-stage ARM pipeline. Resolves operand
//            forwarding, builds Val2 (rotated immediate, zero-extended
//            memory offset or shifted register), runs the ALU, computes the
//            branch target, and owns the NZCV register and EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int SHOP_W  = 12,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               wb_enable_in,
  input  logic               branch_taken_in,
  input  logic               status_write_enable_in,
  input  logic [CMD_W-1:0]   execute_command_in,
  input  logic [DATA_W-1:0]  val_rn_in,
  input  logic [DATA_W-1:0]  val_rm_in,
  input  logic               immediate_in,
  input  logic [23:0]        signed_immediate_in,
  input  logic [SHOP_W-1:0]  shift_operand_in,
  input  logic [RADDR_W-1:0] dest_reg_in,
  input  logic [1:0]         sel_src1,
  input  logic [1:0]         sel_src2,
  input  logic [DATA_W-1:0]  mem_fwd_value,
  input  logic [DATA_W-1:0]  wb_fwd_value,
  output logic               branch_taken_out,
  output logic [ADDR_W-1:0]  branch_address,
  output logic [3:0]         status_out,
  output logic [DATA_W-1:0]  alu_result_out,
  output logic [DATA_W-1:0]  store_data_out,
  output logic [RADDR_W-1:0] dest_reg_out,
  output logic               mem_read_out,
  output logic               mem_write_out,
  output logic               wb_enable_out
);

  // ALU command encodings
  localparam logic [CMD_W-1:0] c_cmd_mov = 4'b0001;
  localparam logic [CMD_W-1:0] c_cmd_mvn = 4'b1001;
  localparam logic [CMD_W-1:0] c_cmd_add = 4'b0010;
  localparam logic [CMD_W-1:0] c_cmd_adc = 4'b0011;
  localparam logic [CMD_W-1:0] c_cmd_sub = 4'b0100;
  localparam logic [CMD_W-1:0] c_cmd_sbc = 4'b0101;
  localparam logic [CMD_W-1:0] c_cmd_and = 4'b0110;
  localparam logic [CMD_W-1:0] c_cmd_orr = 4'b0111;
  localparam logic [CMD_W-1:0] c_cmd_eor = 4'b1000;

  // Register-shift type encodings
  localparam logic [1:0] c_sh_lsl = 2'b00;
  localparam logic [1:0] c_sh_lsr = 2'b01;
  localparam logic [1:0] c_sh_asr = 2'b10;

  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_rm;
  logic [DATA_W-1:0]   w_val2;
  logic [DATA_W-1:0]   w_imm_ext;
  logic [4:0]          w_imm_rot;
  logic [2*DATA_W-1:0] w_imm_dbl;
  logic [4:0]          w_sh_amt;
  logic [1:0]          w_sh_type;
  logic [2*DATA_W-1:0] w_ror_dbl;
  logic [DATA_W-1:0]   w_result;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_cin_ext;
  logic                w_c;
  logic                w_v;
  logic                w_known;
  logic [3:0]          w_status_nxt;
  logic [ADDR_W-1:0]   w_br_off;

  logic [3:0]          r_status;
  logic [DATA_W-1:0]   r_alu_result;
  logic [DATA_W-1:0]   r_store_data;
  logic [RADDR_W-1:0]  r_dest_reg;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_wb_enable;

  // Operand forwarding muxes; codes 00 and 11 both keep the ID/EX value
  always_comb begin
    w_op1 = val_rn_in;
    w_rm  = val_rm_in;
    case (sel_src1)
      2'b01:   w_op1 = mem_fwd_value;
      2'b10:   w_op1 = wb_fwd_value;
      default: w_op1 = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   w_rm = mem_fwd_value;
      2'b10:   w_rm = wb_fwd_value;
      default: w_rm = val_rm_in;
    endcase
  end

  // Rotations are done by shifting a doubled word so an amount of 0 is a pass-through
  assign w_imm_ext = {{(DATA_W-8){1'b0}}, shift_operand_in[7:0]};
  assign w_imm_rot = {shift_operand_in[11:8], 1'b0};
  assign w_imm_dbl = {w_imm_ext, w_imm_ext} >> w_imm_rot;
  assign w_sh_amt  = shift_operand_in[11:7];
  assign w_sh_type = shift_operand_in[6:5];
  assign w_ror_dbl = {w_rm, w_rm} >> w_sh_amt;

  // Val2 selection: rotated immediate, memory offset, or shifted register
  always_comb begin
    w_val2 = w_rm;
    if (immediate_in) begin
      w_val2 = w_imm_dbl[DATA_W-1:0];
    end else if (mem_read_in || mem_write_in) begin
      w_val2 = {{(DATA_W-SHOP_W){1'b0}}, shift_operand_in};
    end else begin
      case (w_sh_type)
        c_sh_lsl: w_val2 = w_rm << w_sh_amt;
        c_sh_lsr: w_val2 = w_rm >> w_sh_amt;
        c_sh_asr: w_val2 = $unsigned($signed(w_rm) >>> w_sh_amt);
        default:  w_val2 = w_ror_dbl[DATA_W-1:0];
      endcase
    end
  end

  assign w_cin_ext = {{DATA_W{1'b0}}, r_status[1]};

  // ALU and flag generation; logic ops keep C/V, unknown codes keep all flags
  always_comb begin
    w_result = '0;
    w_sum    = '0;
    w_c      = r_status[1];
    w_v      = r_status[0];
    w_known  = 1'b1;
    case (execute_command_in)
      c_cmd_mov: w_result = w_val2;
      c_cmd_mvn: w_result = ~w_val2;
      c_cmd_add, c_cmd_adc: begin
        w_sum = {1'b0, w_op1} + {1'b0, w_val2};
        if (execute_command_in == c_cmd_adc) begin
          w_sum = w_sum + w_cin_ext;
        end
        w_result = w_sum[DATA_W-1:0];
        w_c      = w_sum[DATA_W];
        w_v      = (w_op1[DATA_W-1] == w_val2[DATA_W-1]) &&
                   (w_result[DATA_W-1] != w_op1[DATA_W-1]);
      end
      c_cmd_sub, c_cmd_sbc: begin
        // a - b - borrow computed as a + ~b + carry, so carry-out is not-borrow
        w_sum = {1'b0, w_op1} + {1'b0, ~w_val2};
        if (execute_command_in == c_cmd_sbc) begin
          w_sum = w_sum + w_cin_ext;
        end else begin
          w_sum = w_sum + {{DATA_W{1'b0}}, 1'b1};
        end
        w_result = w_sum[DATA_W-1:0];
        w_c      = w_sum[DATA_W];
        w_v      = (w_op1[DATA_W-1] != w_val2[DATA_W-1]) &&
                   (w_result[DATA_W-1] != w_op1[DATA_W-1]);
      end
      c_cmd_and: w_result = w_op1 & w_val2;
      c_cmd_orr: w_result = w_op1 | w_val2;
      c_cmd_eor: w_result = w_op1 ^ w_val2;
      default: begin
        w_result = '0;
        w_known  = 1'b0;
      end
    endcase
    if (w_known) begin
      w_status_nxt = {w_result[DATA_W-1], (w_result == '0), w_c, w_v};
    end else begin
      w_status_nxt = r_status;
    end
  end

  // Branch target: word offset sign-extended, scaled, wraps modulo 2^ADDR_W
  assign w_br_off         = {{(ADDR_W-24){signed_immediate_in[23]}}, signed_immediate_in} << 2;
  assign branch_address   = pc_in + w_br_off;
  assign branch_taken_out = branch_taken_in;

  // NZCV register; a stall drops the update and upstream replays the instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= '0;
    end else if (!freeze && status_write_enable_in) begin
      r_status <= w_status_nxt;
    end
  end

  // EX/MEM pipeline register, held during a memory stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_dest_reg   <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_wb_enable  <= 1'b0;
    end else if (!freeze) begin
      r_alu_result <= w_result;
      r_store_data <= w_rm;
      r_dest_reg   <= dest_reg_in;
      r_mem_read   <= mem_read_in;
      r_mem_write  <= mem_write_in;
      r_wb_enable  <= wb_enable_in;
    end
  end

  assign status_out     = r_status;
  assign alu_result_out = r_alu_result;
  assign store_data_out = r_store_data;
  assign dest_reg_out   = r_dest_reg;
  assign mem_read_out   = r_mem_read;
  assign mem_write_out  = r_mem_write;
  assign wb_enable_out  = r_wb_enable;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage_unit
// Purpose  : Directed self-checking bench for exe_stage_unit with an
//            expected-result queue popped one cycle after each drive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_in;
  logic        mem_read_in, mem_write_in, wb_enable_in;
  logic        branch_taken_in, status_write_enable_in;
  logic [3:0]  execute_command_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic        immediate_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [3:0]  dest_reg_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_value, wb_fwd_value;
  logic        branch_taken_out;
  logic [31:0] branch_address;
  logic [3:0]  status_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [3:0]  dest_reg_out;
  logic        mem_read_out, mem_write_out, wb_enable_out;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dst;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   total = 0;
  int   bad   = 0;

  exe_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in),
    .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
    .execute_command_in(execute_command_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .immediate_in(immediate_in), .signed_immediate_in(signed_immediate_in),
    .shift_operand_in(shift_operand_in), .dest_reg_in(dest_reg_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_value(mem_fwd_value), .wb_fwd_value(wb_fwd_value),
    .branch_taken_out(branch_taken_out), .branch_address(branch_address),
    .status_out(status_out), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .dest_reg_out(dest_reg_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_enable_out(wb_enable_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    mem_read_in = 0; mem_write_in = 0; wb_enable_in = 0;
    branch_taken_in = 0; status_write_enable_in = 0;
    execute_command_in = 4'h0; val_rn_in = 0; val_rm_in = 0;
    immediate_in = 0; shift_operand_in = 0; dest_reg_in = 0;
    sel_src1 = 0; sel_src2 = 0; mem_fwd_value = 0; wb_fwd_value = 0;
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dst,
                      input logic mr, input logic mw, input logic wb, input logic [3:0] nzcv);
    exp_t e;
    e.alu = alu; e.st = st; e.dst = dst; e.mr = mr; e.mw = mw; e.wb = wb; e.nzcv = nzcv;
    q.push_back(e);
    last_exp = e;
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_alu"},  alu_result_out, e.alu);
      chk({tag, "_st"},   store_data_out, e.st);
      chk({tag, "_dst"},  {28'd0, dest_reg_out}, {28'd0, e.dst});
      chk({tag, "_ctl"},  {29'd0, mem_read_out, mem_write_out, wb_enable_out},
                          {29'd0, e.mr, e.mw, e.wb});
      chk({tag, "_nzcv"}, {28'd0, status_out}, {28'd0, e.nzcv});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu"},  alu_result_out, 32'h0);
    chk({tag, "_st"},   store_data_out, 32'h0);
    chk({tag, "_dst"},  {28'd0, dest_reg_out}, 32'h0);
    chk({tag, "_ctl"},  {29'd0, mem_read_out, mem_write_out, wb_enable_out}, 32'h0);
    chk({tag, "_nzcv"}, {28'd0, status_out}, 32'h0);
  endtask

  initial begin
    rst = 0; freeze = 0; pc_in = 0; signed_immediate_in = 0;
    clr();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1;

    // MOV rotated immediate 0xFF ror 4
    clr(); execute_command_in = 4'b0001; immediate_in = 1; shift_operand_in = 12'h2FF;
    val_rm_in = 32'h1234; dest_reg_in = 4'd1; wb_enable_in = 1;
    push(32'hF000000F, 32'h1234, 4'd1, 0, 0, 1, 4'b0000);
    tick_check("mov_imm");

    // CMP 5-5 sets Z and C
    clr(); execute_command_in = 4'b0100; status_write_enable_in = 1;
    val_rn_in = 5; immediate_in = 1; shift_operand_in = 12'h005;
    push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0110);
    tick_check("cmp");

    // ADC 1+1 with carry in
    clr(); execute_command_in = 4'b0011; val_rn_in = 1; immediate_in = 1;
    shift_operand_in = 12'h001; dest_reg_in = 4'd2; wb_enable_in = 1;
    push(32'h3, 32'h0, 4'd2, 0, 0, 1, 4'b0110);
    tick_check("adc");

    // ADD signed overflow
    clr(); execute_command_in = 4'b0010; status_write_enable_in = 1;
    val_rn_in = 32'h7FFFFFFF; immediate_in = 1; shift_operand_in = 12'h001;
    push(32'h80000000, 32'h0, 4'd0, 0, 0, 0, 4'b1001);
    tick_check("add_ovf");

    // Forwarded Rm with ASR #4
    clr(); execute_command_in = 4'b0001; sel_src2 = 2'b01;
    mem_fwd_value = 32'h80000000; val_rm_in = 32'h11111111; shift_operand_in = 12'h240;
    push(32'hF8000000, 32'h80000000, 4'd0, 0, 0, 0, 4'b1001);
    tick_check("fwd_asr");

    // Own Rm with ASR #4
    clr(); execute_command_in = 4'b0001; sel_src2 = 2'b00;
    mem_fwd_value = 32'h80000000; val_rm_in = 32'h40000000; shift_operand_in = 12'h240;
    push(32'h04000000, 32'h40000000, 4'd0, 0, 0, 0, 4'b1001);
    tick_check("own_asr");

    // ROR #4 register shift
    clr(); execute_command_in = 4'b0001; val_rm_in = 32'h000000F1; shift_operand_in = 12'h260;
    push(32'h1000000F, 32'h000000F1, 4'd0, 0, 0, 0, 4'b1001);
    tick_check("ror");

    // ORR with op1 forwarded from write-back
    clr(); execute_command_in = 4'b0111; sel_src1 = 2'b10; wb_fwd_value = 32'h10;
    val_rn_in = 32'h99; immediate_in = 1; shift_operand_in = 12'h00F;
    push(32'h0000001F, 32'h0, 4'd0, 0, 0, 0, 4'b1001);
    tick_check("orr_fwd");

    // LDR address with 12-bit zero-extended offset
    clr(); execute_command_in = 4'b0010; mem_read_in = 1; val_rn_in = 32'h1000;
    shift_operand_in = 12'hABC; dest_reg_in = 4'd3; wb_enable_in = 1;
    push(32'h00001ABC, 32'h0, 4'd3, 1, 0, 1, 4'b1001);
    tick_check("ldr");

    // Freeze for three cycles while inputs and flag writes change
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      clr(); execute_command_in = 4'b0100; status_write_enable_in = 1;
      val_rn_in = 32'h100 + i; immediate_in = 1; shift_operand_in = 12'h007;
      dest_reg_in = 4'd9; mem_write_in = 1;
      push(last_exp.alu, last_exp.st, last_exp.dst, last_exp.mr, last_exp.mw,
           last_exp.wb, last_exp.nzcv);
      tick_check("freeze");
    end
    freeze = 0;

    // SUB 3-5 after release: negative with borrow
    clr(); execute_command_in = 4'b0100; status_write_enable_in = 1;
    val_rn_in = 3; immediate_in = 1; shift_operand_in = 12'h005; dest_reg_in = 4'd4;
    push(32'hFFFFFFFE, 32'h0, 4'd4, 0, 0, 0, 4'b1000);
    tick_check("sub_neg");

    // SBC 10-3 with C clear subtracts an extra 1
    clr(); execute_command_in = 4'b0101; status_write_enable_in = 1;
    val_rn_in = 10; immediate_in = 1; shift_operand_in = 12'h003;
    push(32'h6, 32'h0, 4'd0, 0, 0, 0, 4'b0010);
    tick_check("sbc");

    // Undefined command: zero result, flags untouched
    clr(); execute_command_in = 4'b0000; status_write_enable_in = 1; val_rn_in = 32'h55;
    push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0010);
    tick_check("undef");

    // MVN 0: N set, C/V kept
    clr(); execute_command_in = 4'b1001; status_write_enable_in = 1; immediate_in = 1;
    push(32'hFFFFFFFF, 32'h0, 4'd0, 0, 0, 0, 4'b1010);
    tick_check("mvn");

    // AND to zero, EOR
    clr(); execute_command_in = 4'b0110; status_write_enable_in = 1;
    val_rn_in = 32'hF0; immediate_in = 1; shift_operand_in = 12'h00F;
    push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0110);
    tick_check("and");
    clr(); execute_command_in = 4'b1000; val_rn_in = 32'hFF; immediate_in = 1;
    shift_operand_in = 12'h00F; mem_write_in = 1; val_rm_in = 32'hCAFE;
    immediate_in = 0; shift_operand_in = 12'h00F;
    push(32'h000000FF ^ 32'h0000000F, 32'hCAFE, 4'd0, 0, 1, 0, 4'b0110);
    tick_check("eor_str");

    // Branch target and taken copy, including wrap-around
    pc_in = 32'h100; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1;
    #1;
    chk("br_addr", branch_address, 32'h000000F8);
    chk("br_taken", {31'd0, branch_taken_out}, 32'd1);
    pc_in = 32'h4; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 0;
    #1;
    chk("br_wrap", branch_address, 32'hFFFFFFFC);
    chk("br_ntaken", {31'd0, branch_taken_out}, 32'd0);
    pc_in = 32'h200; signed_immediate_in = 24'h000010;
    #1;
    chk("br_fwd", branch_address, 32'h00000240);

    // Asynchronous reset mid-stall
    freeze = 1;
    #2;
    rst = 0;
    #1;
    chk_zero("async_rst");
    clr(); execute_command_in = 4'b0001; immediate_in = 1; shift_operand_in = 12'h055;
    dest_reg_in = 4'd7; wb_enable_in = 1; val_rm_in = 32'h77;
    freeze = 0;
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1;
    push(32'h55, 32'h77, 4'd7, 0, 0, 1, 4'b0000);
    tick_check("post_rst");

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM pipeline. It consumes the decoded, registered fields from the ID/EX pipeline register, and it produces the EX/MEM register contents.
- Internally it resolves forwarding, generates Val2 (immediate rotate or register shift), runs the ALU and computes the branch target.
- It owns the NZCV status register and the EX/MEM pipeline register, and both honour a memory-stall freeze.

Parameters:
ADDR_W, 32, PC/branch address width
DATA_W, 32, register/ALU data width
CMD_W, 4, execute command width
SHOP_W, 12, shift operand width
RADDR_W, 4, register file address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
freeze  in  1  memory stall; holds EX/MEM register and status register
pc_in  in  ADDR_W  PC+4 of the instruction in EX
mem_read_in, mem_write_in, wb_enable_in  in  1 each  control from ID/EX
branch_taken_in, status_write_enable_in  in  1 each  control from ID/EX
execute_command_in  in  CMD_W  ALU operation
val_rn_in, val_rm_in  in  DATA_W each  register operands
immediate_in  in  1  Val2 from rotated immediate
signed_immediate_in  in  24  branch offset (words)
shift_operand_in  in  SHOP_W  imm/shift field
dest_reg_in  in  RADDR_W  write-back register
sel_src1, sel_src2  in  2 each  forwarding select: 00 own value, 01 mem_fwd_value, 10 wb_fwd_value, 11 own value
mem_fwd_value, wb_fwd_value  in  DATA_W each  forwarded results
branch_taken_out  out  1  combinational copy of branch_taken_in (to IF and flush)
branch_address  out  ADDR_W  combinational pc_in + (sext(signed_imm) << 2)
status_out  out  4  NZCV register contents {N,Z,C,V}
alu_result_out  out  DATA_W  registered ALU result or address
store_data_out  out  DATA_W  registered forwarded Rm (STR data)
dest_reg_out  out  RADDR_W  registered
mem_read_out, mem_write_out, wb_enable_out  out  1 each  registered

Behaviour:
- Reset (rst=0, asynchronous): every registered output and status_out goes to 0 immediately, including mid-stall.
  - Combinational outputs follow their inputs at all times.
- Operand forwarding:
  - op1 = forwarding mux on val_rn_in using sel_src1.
  - rm = forwarding mux on val_rm_in using sel_src2. rm feeds both the Val2 shifter and store_data.
- Val2 generation:
  - immediate_in=1: zero-extend shift_operand[7:0] to 32 bits, then rotate right by 2*shift_operand[11:8].
  - Else, if mem_read_in or mem_write_in: zero-extend shift_operand[11:0].
  - Else: rm shifted by shift_operand[11:7]. The shift type is shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. An amount of 0 passes rm unchanged.
- ALU commands (C_in = status C):
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD/LDR/STR: op1+Val2.
  - 0011 ADC: op1+Val2+C_in.
  - 0100 SUB/CMP: op1-Val2.
  - 0101 SBC: op1-Val2-!C_in.
  - 0110 AND/TST: op1&Val2.
  - 0111 ORR: op1|Val2.
  - 1000 EOR: op1^Val2.
  - Any other code: result 0, flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic: C = 33rd-bit carry. For SUB/SBC, C is the not-borrow. V = signed overflow.
  - Logic/move: C and V keep their previous values.
- Status register update:
  - Loads on a rising edge only when status_write_enable_in=1 and freeze=0.
  - status_out shows the stored value; there is no same-cycle bypass.
- EX/MEM register:
  - When freeze=0, the register loads on each edge. Latency is 1 cycle from ID/EX fields to outputs.
  - When freeze=1, all outputs hold, including the status register.
  - There is no flush input; a branch flushes upstream stages only.
- Branch address: signed_immediate_in is sign-extended to ADDR_W and shifted left 2. The result wraps modulo 2^ADDR_W.
- Simultaneous freeze with status_write_enable_in: freeze wins, and the flag update is lost. The upstream hazard logic holds the instruction in place.

Test Plan:
- Reset/hold: assert rst=0 mid-stream with freeze=1 -> all registered outputs and status_out read 0 immediately. Release rst, and the first edge loads the current inputs.
- Immediate rotate: cmd 0001, immediate_in=1, shift_operand=12'h2FF (imm8 0xFF, rot 2*2=4) -> alu_result_out=32'hF000000F, one cycle later.
- Flags: cmd 0100, status_write_enable_in=1, rn=5, immediate val2=5 -> status_out=4'b0110 (Z=1,C=1) after the edge. Then ADD 0x7FFFFFFF+1 -> NZCV=4'b1001.
- Forwarding/shift: sel_src2=01, mem_fwd_value=32'h80000000, shift_operand ASR #4 (12'h240), cmd 0001 -> result 32'hF8000000. With sel_src2=00 the result comes from val_rm_in.
- Freeze: freeze=1 for 3 cycles while inputs change -> all registered outputs and status_out are unchanged. After release, the next edge captures the current inputs.
- Branch/ADC: signed_immediate=24'hFFFFFE, pc_in=0x100 -> branch_address=0xF8 combinationally. ADC 1+1 with C=1 -> 3.
